// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt controller and its testbench.
package int_pkg;

    localparam int NUM_SRC = 4;
    localparam int CAUSE_W = 2;
    localparam logic [15:0] HANDLER_PC = 16'h0005;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        SERVICE
    } state_t;

    // Bit 0 is the highest priority, so the lowest set index wins.
    function automatic logic [CAUSE_W-1:0] lowest_index(input logic [NUM_SRC-1:0] vec);
        logic [CAUSE_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = CAUSE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/int_edge_det.sv
// Rising-edge detector: one previous-value register per source, rise = cur & ~prev.
module int_edge_det #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
        end else begin
            prev <= cur;
        end
    end

    assign rise = cur & ~prev;

endmodule

// File: rtl/int_ctrl.sv
// Four-source prioritised interrupt controller with request/ack/return handshake to fetch.
// Optional runtime source mask is enabled by defining INT_MASK_EN.
module int_ctrl
    import int_pkg::*;
#(
    parameter int ACK_TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               int_ack,
    input  logic               int_done,
`ifdef INT_MASK_EN
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_data,
`endif
    output logic               ipu_int,
    output logic [CAUSE_W-1:0] int_cause,
    output logic               int_active,
    output logic [NUM_SRC-1:0] pending
);

    // Timeout compares against a 3-bit counter, so ACK_TIMEOUT must lie in 1..8.
    localparam logic [2:0] ACK_LAST = 3'(ACK_TIMEOUT - 1);

    state_t             state;
    state_t             state_next;
    logic [CAUSE_W-1:0] cause_next;
    logic [2:0]         wait_cnt;
    logic [2:0]         wait_cnt_next;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] clr;

    int_edge_det #(
        .WIDTH(NUM_SRC)
    ) u_edge_det (
        .clk  (clk),
        .rst  (rst),
        .cur  (src_irq),
        .rise (rise)
    );

`ifdef INT_MASK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '1;
        end else if (mask_wr) begin
            mask <= mask_data;
        end
    end
`else
    assign mask = '1;
`endif

    // A new edge is OR-ed in after the clear, so a set coinciding with a return wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr) | rise;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            int_cause <= '0;
            wait_cnt  <= '0;
        end else begin
            state     <= state_next;
            int_cause <= cause_next;
            wait_cnt  <= wait_cnt_next;
        end
    end

    // IDLE always lasts at least one cycle, which spaces successive requests two cycles apart.
    always_comb begin
        state_next    = state;
        cause_next    = int_cause;
        wait_cnt_next = wait_cnt;
        clr           = '0;
        ipu_int       = 1'b0;
        int_active    = 1'b0;
        case (state)
            IDLE: begin
                if ((pending & mask) != '0) begin
                    state_next = REQ;
                    cause_next = lowest_index(pending & mask);
                end
            end
            REQ: begin
                ipu_int       = 1'b1;
                wait_cnt_next = '0;
                state_next    = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (wait_cnt != 3'b111) begin
                    wait_cnt_next = wait_cnt + 3'd1;
                end
                if (int_ack) begin
                    state_next = SERVICE;
                end else if (wait_cnt >= ACK_LAST) begin
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                int_active = 1'b1;
                if (int_done) begin
                    clr        = NUM_SRC'(1) << int_cause;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard testbench for int_ctrl; covers the INT_MASK_EN build when that macro is defined.
module tb_int_ctrl;
    import int_pkg::*;

    typedef struct packed {
        logic [CAUSE_W-1:0] cause;
        logic [NUM_SRC-1:0] pend;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_SRC-1:0] src_irq;
    logic               int_ack;
    logic               int_done;
`ifdef INT_MASK_EN
    logic               mask_wr;
    logic [NUM_SRC-1:0] mask_data;
`endif
    logic               ipu_int;
    logic [CAUSE_W-1:0] int_cause;
    logic               int_active;
    logic [NUM_SRC-1:0] pending;

    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_ipu = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   w;

    int_ctrl #(.ACK_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_irq    (src_irq),
        .int_ack    (int_ack),
        .int_done   (int_done),
`ifdef INT_MASK_EN
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
`endif
        .ipu_int    (ipu_int),
        .int_cause  (int_cause),
        .int_active (int_active),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_SRC-1:0] src);
        @(negedge clk);
        src_irq = src;
    endtask

    task automatic wait_req(input int max, output int waited);
        waited = 0;
        while (waited < max) begin
            @(negedge clk);
            waited++;
            if (ipu_int === 1'b1) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL wait_req: no ipu_int within %0d cycles", max);
        waited = -1;
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        checkOutput({tag, "_active_after_ack"}, int_active, 1);
        checkOutput({tag, "_ipu_low_in_service"}, ipu_int, 0);
    endtask

    task automatic do_done(input int gap, input string tag, input logic [NUM_SRC-1:0] pend_after);
        repeat (gap - 1) @(negedge clk);
        checkOutput({tag, "_active_before_done"}, int_active, 1);
        int_done = 1'b1;
        @(negedge clk);
        int_done = 1'b0;
        checkOutput({tag, "_active_after_done"}, int_active, 0);
        checkOutput({tag, "_pending_after_done"}, pending, pend_after);
    endtask

    // Monitor: every ipu_int cycle consumes one expected request.
    always @(negedge clk) begin
        if (rst) begin
            prev_ipu = 1'b0;
        end else begin
            if (ipu_int) begin
                checkOutput("ipu_single_cycle", prev_ipu, 0);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_req: cause %0d pending %b", int_cause, pending);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("req_cause", int_cause, mon_e.cause);
                    checkOutput("req_pending", pending, mon_e.pend);
                end
            end
            prev_ipu = ipu_int;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        src_irq  = '0;
        int_ack  = 1'b0;
        int_done = 1'b0;
`ifdef INT_MASK_EN
        mask_wr   = 1'b0;
        mask_data = '0;
`endif
        repeat (2) @(negedge clk);
        checkOutput("reset_ipu", ipu_int, 0);
        checkOutput("reset_cause", int_cause, 0);
        checkOutput("reset_active", int_active, 0);
        checkOutput("reset_pending", pending, 0);
        rst = 1'b0;

        // Stray ack/done in IDLE must be ignored.
        @(negedge clk);
        int_ack  = 1'b1;
        int_done = 1'b1;
        @(negedge clk);
        int_ack  = 1'b0;
        int_done = 1'b0;
        @(negedge clk);
        checkOutput("stray_active", int_active, 0);
        checkOutput("stray_pending", pending, 0);

        // Single event on source 2.
        exp_q.push_back('{2'd2, 4'b0100});
        src_irq = 4'b0100;
        wait_req(8, w);
        checkOutput("t1_latency", w, 2);
        do_ack("t1");
        checkOutput("t1_cause_held", int_cause, 2);
        do_done(10, "t1", 4'b0000);
        applyStimulus(4'b0000);

        // Priority plus a merged second edge on source 3.
        applyStimulus(4'b1010);
        exp_q.push_back('{2'd1, 4'b1010});
        exp_q.push_back('{2'd3, 4'b1000});
        wait_req(8, w);
        checkOutput("t2_latency", w, 2);
        do_ack("t2a");
        applyStimulus(4'b0010);
        applyStimulus(4'b1010);
        @(negedge clk);
        checkOutput("t2_merge_pending", pending, 4'b1010);
        checkOutput("t2_cause_held", int_cause, 1);
        do_done(3, "t2a", 4'b1000);
        wait_req(8, w);
        checkOutput("t2_gap_min", (w >= 1), 1);
        do_ack("t2b");
        do_done(3, "t2b", 4'b0000);
        applyStimulus(4'b0000);

        // Ack timeout and retry on source 0.
        applyStimulus(4'b0001);
        exp_q.push_back('{2'd0, 4'b0001});
        exp_q.push_back('{2'd0, 4'b0001});
        wait_req(8, w);
        checkOutput("t3_latency", w, 2);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checkOutput("t3_pending_kept", pending, 4'b0001);
            checkOutput("t3_ipu_timing", ipu_int, (i == 6));
        end
        do_ack("t3");
        do_done(3, "t3", 4'b0000);
        applyStimulus(4'b0000);

        // New edge on source 0 coinciding with its int_done.
        applyStimulus(4'b0001);
        exp_q.push_back('{2'd0, 4'b0001});
        exp_q.push_back('{2'd0, 4'b0001});
        wait_req(8, w);
        do_ack("t4a");
        applyStimulus(4'b0000);
        @(negedge clk);
        src_irq  = 4'b0001;
        int_done = 1'b1;
        @(negedge clk);
        int_done = 1'b0;
        checkOutput("t4_active_after_done", int_active, 0);
        checkOutput("t4_set_wins", pending, 4'b0001);
        wait_req(8, w);
        checkOutput("t4_rerequest", w, 1);
        do_ack("t4b");
        do_done(3, "t4b", 4'b0000);
        applyStimulus(4'b0000);

        // Reset while in service with two events pending.
        applyStimulus(4'b0010);
        exp_q.push_back('{2'd1, 4'b0010});
        wait_req(8, w);
        do_ack("t5");
        applyStimulus(4'b1010);
        @(negedge clk);
        checkOutput("t5_pending_before_rst", pending, 4'b1010);
        rst     = 1'b1;
        src_irq = 4'b0000;
        #1;
        checkOutput("t5_rst_ipu", ipu_int, 0);
        checkOutput("t5_rst_cause", int_cause, 0);
        checkOutput("t5_rst_active", int_active, 0);
        checkOutput("t5_rst_pending", pending, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("t5_quiet_ipu", ipu_int, 0);
        end
        exp_q.push_back('{2'd2, 4'b0100});
        src_irq = 4'b0100;
        wait_req(8, w);
        checkOutput("t5_latency", w, 2);
        do_ack("t5b");
        do_done(3, "t5b", 4'b0000);
        applyStimulus(4'b0000);

`ifdef INT_MASK_EN
        // Masked source latches but is not requested until unmasked.
        @(negedge clk);
        mask_data = 4'b1110;
        mask_wr   = 1'b1;
        @(negedge clk);
        mask_wr = 1'b0;
        src_irq = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("t6_masked_ipu", ipu_int, 0);
        end
        checkOutput("t6_masked_pending", pending, 4'b0001);
        exp_q.push_back('{2'd0, 4'b0001});
        mask_data = 4'hF;
        mask_wr   = 1'b1;
        @(negedge clk);
        mask_wr = 1'b0;
        wait_req(8, w);
        checkOutput("t6_unmask_latency", w, 1);
        do_ack("t6");
        do_done(3, "t6", 4'b0000);
        applyStimulus(4'b0000);
`endif

        repeat (4) @(negedge clk);
        checkOutput("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
